// File: rtl/hy_cnt_evt_q.sv
`default_nettype none
// ============================================================================
// Module      : hy_cnt_evt_q
// Description : Event capture queue for the hyCnt counter. A rising edge on
//               the counter's terminal-count interrupt snapshots the counter
//               value together with a free-running timestamp. Snapshots go
//               into a small first-word-fall-through FIFO and are handed to
//               the consumer over a valid/ready handshake. Events dropped
//               because the queue was full are counted (saturating at 255).
//
// Ports       : clk        clock, all logic on the rising edge
//               rst        synchronous active-high reset
//               int_in     hyCnt interrupt level (edge-detected here)
//               cnt_in     hyCnt counter value, sampled on an event
//               en         capture enable (queue keeps draining when low)
//               clr        synchronous flush of the queue and loss counter
//               evt_valid  head entry available
//               evt_ready  consumer accepts the head entry
//               evt_cnt    head entry counter value
//               evt_stamp  head entry timestamp
//               evt_level  queue occupancy, 0..DEPTH
//               evt_lost   dropped-event count, saturating at 255
//
// Revision    : 1.0 - initial release
// ============================================================================
module hy_cnt_evt_q #(
    parameter int C_WIDTH     = 8,
    parameter int DEPTH       = 4,
    parameter int STAMP_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       int_in,
    input  logic [C_WIDTH-1:0]         cnt_in,
    input  logic                       en,
    input  logic                       clr,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [C_WIDTH-1:0]         evt_cnt,
    output logic [STAMP_WIDTH-1:0]     evt_stamp,
    output logic [$clog2(DEPTH):0]     evt_level,
    output logic [7:0]                 evt_lost
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                       r_int_d;
    logic [STAMP_WIDTH-1:0]     r_stamp;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_LVL_W-1:0]         r_level;
    logic [7:0]                 r_lost;

    logic [C_WIDTH-1:0]         r_mem_cnt   [DEPTH];
    logic [STAMP_WIDTH-1:0]     r_mem_stamp [DEPTH];

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic w_event;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_event = int_in & ~r_int_d & en;
    assign w_full  = (r_level == c_LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);

    // A pop frees the head slot in the same edge, so a full queue can still
    // take an event when the consumer is draining. When full, the write
    // pointer equals the read pointer: the popped head is overwritten by the
    // new tail entry, which is safe because the head was already presented.
    assign w_pop   = ~clr & ~w_empty & evt_ready;
    assign w_push  = ~clr & w_event & (~w_full | w_pop);
    assign w_drop  = ~clr & w_event & w_full & ~w_pop;

    // ------------------------------------------------------------------------
    // Edge detect and timestamp: only reset affects these, not clr.
    // int_d resets high so an interrupt already asserted at reset release
    // does not look like a fresh edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_d <= 1'b1;
            r_stamp <= '0;
        end else begin
            r_int_d <= int_in;
            r_stamp <= r_stamp + STAMP_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_lost   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_W'(1);
            end
            if (w_drop && (r_lost != 8'hFF)) begin
                r_lost <= r_lost + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: contents need no reset, only the pointers qualify them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cnt[r_wr_ptr]   <= cnt_in;
            r_mem_stamp[r_wr_ptr] <= r_stamp;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: head entry falls through directly from storage.
    // ------------------------------------------------------------------------
    assign evt_valid = ~w_empty;
    assign evt_cnt   = r_mem_cnt[r_rd_ptr];
    assign evt_stamp = r_mem_stamp[r_rd_ptr];
    assign evt_level = r_level;
    assign evt_lost  = r_lost;

endmodule
`default_nettype wire
